alu_registerfile_2r1w: RTL and testbench

Parametrised register file for the ALU datapath: one write port with byte enables, two independent read ports with registered outputs and write-to-read bypass, and a sequential bulk-clear engine. It supersedes the fixed 16 x 32 single-read-port file and feeds both ALU operand buses in the same cycle.

---
 rtl/alu_rf_pkg.sv | 32 +++
 rtl/alu_registerfile_clr_ctrl.sv | 67 ++++++
 rtl/alu_registerfile_2r1w.sv | 109 ++++++++++
 tb/tb_alu_registerfile_2r1w.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rf_pkg.sv
// Shared constants, clear-FSM state type and byte-lane merge helper for the ALU register file.
package alu_rf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 16;

    // Widest word the merge helper handles; callers cast down to their own width.
    localparam int unsigned MERGE_W    = 256;
    localparam int unsigned MERGE_BE_W = MERGE_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clrState_e;

    // Enabled byte lanes come from newVal, the rest keep oldVal.
    function automatic logic [MERGE_W-1:0] byteMerge(
        input logic [MERGE_W-1:0]    oldVal,
        input logic [MERGE_W-1:0]    newVal,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = oldVal;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = newVal[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_registerfile_clr_ctrl.sv
// Bulk-clear sequencer: walks a pointer over every entry, one per cycle, and reports busy.
module alu_registerfile_clr_ctrl
    import alu_rf_pkg::*;
#(
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    output logic              busy,
    output logic              wReady,
    output logic              clrWe,
    output logic [ADDR_W-1:0] clrAddr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clrState_e         state;
    clrState_e         stateNext;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptrNext;

    // State and pointer registers; reset aborts any sweep in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
        end
    end

    // Next state: start on clear in IDLE, leave CLEAR after the last entry; clear is ignored mid-sweep.
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        case (state)
            IDLE: begin
                if (clear) begin
                    stateNext = CLEAR;
                    ptrNext   = '0;
                end
            end
            CLEAR: begin
                if (ptr == LAST_ADDR) begin
                    stateNext = IDLE;
                    ptrNext   = '0;
                end else begin
                    ptrNext = ptr + ADDR_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                ptrNext   = '0;
            end
        endcase
    end

    // Status and clear strobe decode straight from the state/pointer registers.
    assign busy    = (state == CLEAR);
    assign wReady  = (state != CLEAR);
    assign clrWe   = (state == CLEAR);
    assign clrAddr = ptr;

endmodule

// File: rtl/alu_registerfile_2r1w.sv
// Two-read / one-write register file with byte enables, write and clear bypass, and bulk clear.
module alu_registerfile_2r1w
    import alu_rf_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic [BE_W-1:0]   wBe,
    output logic              wReady,
    input  logic [ADDR_W-1:0] rAddr0,
    output logic [DATA_W-1:0] rData0,
    input  logic [ADDR_W-1:0] rAddr1,
    output logic [DATA_W-1:0] rData1,
    input  logic              clear,
    output logic              busy
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clrWe;
    logic [ADDR_W-1:0] clrAddr;
    logic              wAddrOk;
    logic              wCommit;
    logic [DATA_W-1:0] wOld;
    logic [DATA_W-1:0] wMerged;
    logic [DATA_W-1:0] rNext0;
    logic [DATA_W-1:0] rNext1;

    alu_registerfile_clr_ctrl #(
        .DEPTH (DEPTH)
    ) uClrCtrl (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .busy    (busy),
        .wReady  (wReady),
        .clrWe   (clrWe),
        .clrAddr (clrAddr)
    );

    // Write qualification and the merged word an accepted write leaves in the entry.
    assign wAddrOk = ({1'b0, wAddr} < DEPTH_L);
    assign wCommit = we & wReady & wAddrOk;
    assign wOld    = wAddrOk ? mem[wAddr] : '0;
    assign wMerged = DATA_W'(byteMerge(MERGE_W'(wOld), MERGE_W'(wData), MERGE_BE_W'(wBe)));

    // Per-entry storage; writes and clear strobes never coincide since writes stall while busy.
    for (genvar e = 0; e < DEPTH; e++) begin : gEntry
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mem[e] <= '0;
            end else if (wCommit && (wAddr == ADDR_W'(e))) begin
                mem[e] <= wMerged;
            end else if (clrWe && (clrAddr == ADDR_W'(e))) begin
                mem[e] <= '0;
            end
        end
    end

    // Port 0 next value: the entry's contents after this edge, zero when out of range.
    always_comb begin
        rNext0 = '0;
        if ({1'b0, rAddr0} < DEPTH_L) begin
            if (clrWe && (clrAddr == rAddr0)) begin
                rNext0 = '0;
            end else if (wCommit && (wAddr == rAddr0)) begin
                rNext0 = wMerged;
            end else begin
                rNext0 = mem[rAddr0];
            end
        end
    end

    // Port 1 next value: same rules as port 0 on its own address.
    always_comb begin
        rNext1 = '0;
        if ({1'b0, rAddr1} < DEPTH_L) begin
            if (clrWe && (clrAddr == rAddr1)) begin
                rNext1 = '0;
            end else if (wCommit && (wAddr == rAddr1)) begin
                rNext1 = wMerged;
            end else begin
                rNext1 = mem[rAddr1];
            end
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rData0 <= '0;
            rData1 <= '0;
        end else begin
            rData0 <= rNext0;
            rData1 <= rNext1;
        end
    end

endmodule

// File: tb/tb_alu_registerfile_2r1w.sv
// Bench for alu_registerfile_2r1w: a 16-entry and a 12-entry instance share one stimulus stream
// and are compared every cycle against a behavioural model, plus hand-computed spot checks.
module tb_alu_registerfile_2r1w;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic        clear;
    logic [3:0]  wAddr;
    logic [31:0] wData;
    logic [3:0]  wBe;
    logic [3:0]  rAddr0;
    logic [3:0]  rAddr1;

    logic [31:0] rData0A, rData1A, rData0B, rData1B;
    logic        busyA, busyB, wReadyA, wReadyB;

    alu_registerfile_2r1w #(.DATA_W(32), .DEPTH(16)) dutA (
        .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData), .wBe(wBe),
        .wReady(wReadyA), .rAddr0(rAddr0), .rData0(rData0A), .rAddr1(rAddr1), .rData1(rData1A),
        .clear(clear), .busy(busyA)
    );

    alu_registerfile_2r1w #(.DATA_W(32), .DEPTH(12)) dutB (
        .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData), .wBe(wBe),
        .wReady(wReadyB), .rAddr0(rAddr0), .rData0(rData0B), .rAddr1(rAddr1), .rData1(rData1B),
        .clear(clear), .busy(busyB)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    // Model state: index 0 mirrors the 16-entry instance, index 1 the 12-entry one.
    int          depthOf [2];
    logic [31:0] mMem    [2][16];
    bit          mBusy   [2];
    int          mPtr    [2];
    logic [31:0] expR0   [2];
    logic [31:0] expR1   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mMem[d][i] = '0;
            mBusy[d] = 1'b0;
            mPtr[d]  = 0;
            expR0[d] = '0;
            expR1[d] = '0;
        end
    endtask

    // One rising edge: reads return what each entry holds once the edge has taken effect.
    task automatic modelStep();
        logic [31:0] nxt [16];
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) nxt[i] = mMem[d][i];
            if (we && !mBusy[d] && (int'(wAddr) < depthOf[d])) begin
                for (int b = 0; b < 4; b++) begin
                    if (wBe[b]) nxt[wAddr][8*b +: 8] = wData[8*b +: 8];
                end
            end
            if (mBusy[d]) nxt[mPtr[d]] = '0;
            expR0[d] = (int'(rAddr0) < depthOf[d]) ? nxt[rAddr0] : 32'h0;
            expR1[d] = (int'(rAddr1) < depthOf[d]) ? nxt[rAddr1] : 32'h0;
            for (int i = 0; i < 16; i++) mMem[d][i] = nxt[i];
            if (mBusy[d]) begin
                mPtr[d]++;
                if (mPtr[d] == depthOf[d]) begin
                    mBusy[d] = 1'b0;
                    mPtr[d]  = 0;
                end
            end else if (clear) begin
                mBusy[d] = 1'b1;
                mPtr[d]  = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checkEn && reset_n) begin
            chk("rData0_d16", rData0A, expR0[0]);
            chk("rData1_d16", rData1A, expR1[0]);
            chk("busy_d16", 32'(busyA), 32'(mBusy[0]));
            chk("wReady_d16", 32'(wReadyA), 32'(!mBusy[0]));
            chk("rData0_d12", rData0B, expR0[1]);
            chk("rData1_d12", rData1B, expR1[1]);
            chk("busy_d12", 32'(busyB), 32'(mBusy[1]));
            chk("wReady_d12", 32'(wReadyB), 32'(!mBusy[1]));
        end
    end

    int cntA;
    int cntB;

    initial begin
        depthOf[0] = 16;
        depthOf[1] = 12;
        modelReset();
        reset_n = 1'b1;
        we      = 1'b0;
        clear   = 1'b0;
        wAddr   = '0;
        wData   = '0;
        wBe     = '0;
        rAddr0  = '0;
        rAddr1  = '0;

        // Asynchronous reset mid-cycle, observed before any rising edge.
        #4 reset_n = 1'b0;
        modelReset();
        #2;
        chk("rst_rData0_d16", rData0A, 32'h0);
        chk("rst_rData1_d16", rData1A, 32'h0);
        chk("rst_busy_d16", 32'(busyA), 32'h0);
        chk("rst_wReady_d16", 32'(wReadyA), 32'h1);
        chk("rst_busy_d12", 32'(busyB), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkEn = 1'b1;

        // Every entry reads zero after reset.
        for (int a = 0; a < 16; a++) begin
            rAddr0 = 4'(a);
            rAddr1 = 4'(15 - a);
            step();
            chk("rst_readAll_d16", rData0A, 32'h0);
        end

        // Full-word write then a single-lane overwrite.
        we = 1'b1; wAddr = 4'd1; wData = 32'h5BBDF7EF; wBe = 4'hF;
        step();
        wData = 32'h000000AA; wBe = 4'h1;
        step();
        we = 1'b0; rAddr0 = 4'd1; rAddr1 = 4'd1;
        step();
        chk("byteWrite_d16", rData0A, 32'h5BBDF7AA);
        chk("byteWrite_d12", rData1B, 32'h5BBDF7AA);

        // Same-cycle write bypass on both ports, then independent addresses.
        we = 1'b1; wAddr = 4'd7; wData = 32'hB77BEFDF; wBe = 4'hF; rAddr0 = 4'd7; rAddr1 = 4'd7;
        step();
        chk("bypass_p0_d16", rData0A, 32'hB77BEFDF);
        chk("bypass_p1_d16", rData1A, 32'hB77BEFDF);
        we = 1'b0; rAddr0 = 4'd15; rAddr1 = 4'd1;
        step();
        chk("indep_p0_d16", rData0A, 32'h0);
        chk("indep_p1_d16", rData1A, 32'h5BBDF7AA);
        chk("oor_p0_d12", rData0B, 32'h0);

        // Fill with index+1, then sweep; a write and a re-clear arrive mid-sweep.
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; wAddr = 4'(i); wData = 32'(i + 1); wBe = 4'hF;
            step();
        end
        we = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        cntA = 0;
        cntB = 0;
        for (int k = 0; k < 30; k++) begin
            if (busyA) cntA++;
            if (busyB) cntB++;
            if (k == 4) begin
                chk("sweepRead10_d16", rData0A, 32'd11);
                chk("sweepRead10_d12", rData0B, 32'd11);
            end
            case (k)
                1: begin we = 1'b1; wAddr = 4'd3; wData = 32'h1234; wBe = 4'hF; end
                2: we = 1'b0;
                3: rAddr0 = 4'd10;
                5: clear = 1'b1;
                6: clear = 1'b0;
                default: ;
            endcase
            step();
        end
        chk("sweepLen_d16", 32'(cntA), 32'd16);
        chk("sweepLen_d12", 32'(cntB), 32'd12);
        rAddr0 = 4'd10; rAddr1 = 4'd3;
        step();
        chk("afterSweep10_d16", rData0A, 32'h0);
        chk("afterSweep3_d16", rData1A, 32'h0);
        chk("afterSweep3_d12", rData1B, 32'h0);

        // Address 13 is out of range for the 12-entry instance only.
        we = 1'b1; wAddr = 4'd13; wData = 32'hDEADBEEF; wBe = 4'hF; rAddr0 = 4'd13; rAddr1 = 4'd13;
        step();
        we = 1'b0;
        chk("oorWrite_d12", rData0B, 32'h0);
        chk("bypass13_d16", rData0A, 32'hDEADBEEF);

        // Randomised traffic, with reads biased toward the write address.
        repeat (1500) begin
            we     = 1'($urandom_range(0, 1));
            wAddr  = 4'($urandom);
            wData  = $urandom;
            wBe    = 4'($urandom);
            rAddr0 = ($urandom_range(0, 3) == 0) ? wAddr : 4'($urandom);
            rAddr1 = ($urandom_range(0, 3) == 0) ? wAddr : 4'($urandom);
            clear  = ($urandom_range(0, 39) == 0);
            step();
        end
        clear = 1'b0;
        we    = 1'b0;
        repeat (20) step();

        // Reset at sweep cycle 5 aborts the sweep immediately.
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (5) step();
        chk("midSweepBusy_d12", 32'(busyB), 32'h1);
        reset_n = 1'b0;
        modelReset();
        #2;
        chk("abortBusy_d16", 32'(busyA), 32'h0);
        chk("abortBusy_d12", 32'(busyB), 32'h0);
        chk("abortWReady_d12", 32'(wReadyB), 32'h1);
        chk("abortRData0_d12", rData0B, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rAddr0 = 4'(a);
            rAddr1 = 4'(15 - a);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
